// File: rtl/ysyx_25020077_imm_encoder_if.sv
// Request/response bundle for the RV32I immediate encoder.
// The slave side is the encoder; the master side is whoever issues requests and drains words.
interface ysyx_25020077_imm_encoder_if;
   logic        io_in_valid;
   logic        io_in_ready;
   logic [2:0]  io_in_imm_type;
   logic [31:0] io_in_imm;
   logic [6:0]  io_in_opcode;
   logic [2:0]  io_in_funct3;
   logic [4:0]  io_in_rd;
   logic [4:0]  io_in_rs1;
   logic [4:0]  io_in_rs2;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [31:0] io_out_instruction;
   logic        io_out_err;
   logic [7:0]  io_err_count;

   modport slave (
      input  io_in_valid, io_in_imm_type, io_in_imm, io_in_opcode, io_in_funct3,
             io_in_rd, io_in_rs1, io_in_rs2, io_out_ready,
      output io_in_ready, io_out_valid, io_out_instruction, io_out_err, io_err_count
   );

   modport master (
      output io_in_valid, io_in_imm_type, io_in_imm, io_in_opcode, io_in_funct3,
             io_in_rd, io_in_rs1, io_in_rs2, io_out_ready,
      input  io_in_ready, io_out_valid, io_out_instruction, io_out_err, io_err_count
   );
endinterface

// File: rtl/ysyx_25020077_imm_encoder.sv
// Packs instruction fields and an immediate into an RV32I word (I/S/B/U/J) behind a 2-entry FIFO.
// Define YSYX_25020077_IMMENC_RANGECHK_EN to also flag immediates that do not fit their format.
module ysyx_25020077_imm_encoder (
   input  logic                              clock,
   input  logic                              reset,
   ysyx_25020077_imm_encoder_if.slave        io
);

   typedef enum logic [2:0] {
      IMM_I = 3'd1,
      IMM_S = 3'd2,
      IMM_B = 3'd3,
      IMM_U = 3'd4,
      IMM_J = 3'd5
   } immType_e;

   logic [31:0] imm;
   logic [31:0] encWord;
   logic        typeErr;
   logic        encErr;

   assign imm = io.io_in_imm;

   always_comb begin
      encWord = '0;
      typeErr = 1'b0;
      case (io.io_in_imm_type)
         IMM_I: encWord = {imm[11:0], io.io_in_rs1, io.io_in_funct3, io.io_in_rd, io.io_in_opcode};
         IMM_S: encWord = {imm[11:5], io.io_in_rs2, io.io_in_rs1, io.io_in_funct3,
                           imm[4:0], io.io_in_opcode};
         IMM_B: encWord = {imm[12], imm[10:5], io.io_in_rs2, io.io_in_rs1, io.io_in_funct3,
                           imm[4:1], imm[11], io.io_in_opcode};
         IMM_U: encWord = {imm[31:12], io.io_in_rd, io.io_in_opcode};
         IMM_J: encWord = {imm[20], imm[10:1], imm[11], imm[19:12], io.io_in_rd, io.io_in_opcode};
         default: typeErr = 1'b1;
      endcase
   end

`ifdef YSYX_25020077_IMMENC_RANGECHK_EN
   logic rangeErr;

   // Upper bits beyond each format's sign bit must be a pure sign extension.
   always_comb begin
      rangeErr = 1'b0;
      case (io.io_in_imm_type)
         IMM_I, IMM_S: rangeErr = !((&imm[31:11]) || !(|imm[31:11]));
         IMM_B:        rangeErr = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         IMM_U:        rangeErr = |imm[11:0];
         IMM_J:        rangeErr = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         default:      rangeErr = 1'b0;
      endcase
   end

   assign encErr = typeErr | rangeErr;
`else
   assign encErr = typeErr;
`endif

   logic [32:0] mem_q [2];
   logic        wrPtr_q, wrPtr_d;
   logic        rdPtr_q, rdPtr_d;
   logic [1:0]  count_q, count_d;
   logic [7:0]  errCount_q, errCount_d;
   logic        inReady;
   logic        outValid;
   logic        push;
   logic        pop;
   logic [32:0] head;

   // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
   assign inReady  = (count_q < 2'd2);
   assign outValid = (count_q != 2'd0);
   assign push     = io.io_in_valid && inReady;
   assign pop      = outValid && io.io_out_ready;

   always_comb begin
      wrPtr_d    = push ? ~wrPtr_q : wrPtr_q;
      rdPtr_d    = pop  ? ~rdPtr_q : rdPtr_q;
      count_d    = count_q;
      errCount_d = errCount_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
      if (push && encErr && (errCount_q != 8'hFF)) begin
         errCount_d = errCount_q + 8'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr_q    <= 1'b0;
         rdPtr_q    <= 1'b0;
         count_q    <= 2'd0;
         errCount_q <= 8'd0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         errCount_q <= errCount_d;
      end
   end

   // Storage is deliberately unreset; the empty-FIFO gating below hides stale contents.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wrPtr_q] <= {encErr, encWord};
      end
   end

   assign head                  = mem_q[rdPtr_q];
   assign io.io_in_ready        = inReady;
   assign io.io_out_valid       = outValid;
   assign io.io_out_instruction = outValid ? head[31:0] : 32'h0000_0000;
   assign io.io_out_err         = outValid ? head[32]   : 1'b0;
   assign io.io_err_count       = errCount_q;

endmodule

// File: doc/ysyx_25020077_imm_encoder.md
# ysyx_25020077_imm_encoder

- Packs separate instruction fields and a 32-bit immediate into a 32-bit RV32I instruction word, for I/S/B/U/J formats.
- It is the inverse of the immediate decoder that extracts `io_imm` from `io_instruction`.
- It is used by the self-test instruction generator and the trap-stub builder to synthesise instructions at run time.
- Input and output use valid/ready handshakes, with a 2-entry output FIFO between them.

## Interface
- No parameters. Widths are fixed for RV32.
- `clock` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `io_in_valid` input 1: request valid.
- `io_in_ready` output 1: encoder can accept a request.
- `io_in_imm_type` input 3: immediate format; 1=I, 2=S, 3=B, 4=U, 5=J; 0/6/7 illegal.
- `io_in_imm` input 32: immediate value, sign-extended byte offset or value.
- `io_in_opcode` input 7: opcode field.
- `io_in_funct3` input 3: funct3 field.
- `io_in_rd`, `io_in_rs1`, `io_in_rs2` input 5 each: register fields.
- `io_out_valid` output 1: encoded word available.
- `io_out_ready` input 1: consumer accepts the word.
- `io_out_instruction` output 32: encoded word, head of FIFO.
- `io_out_err` output 1: error flag of the head entry.
- `io_err_count` output 8: saturating count of accepted requests with err=1.

## Operation
- An input transfer happens when `io_in_valid && io_in_ready`. The encoded word and its err bit are written into the FIFO tail in the same cycle.
- An output transfer happens when `io_out_valid && io_out_ready`. It pops the FIFO head.
- Bit packing, with i = `io_in_imm`:
  - I: i[11:0]→[31:20], rs1→[19:15], funct3→[14:12], rd→[11:7], opcode→[6:0].
  - S: i[11:5]→[31:25], rs2→[24:20], rs1, funct3, i[4:0]→[11:7], opcode.
  - B: i[12]→31, i[10:5]→[30:25], rs2, rs1, funct3, i[4:1]→[11:8], i[11]→7, opcode.
  - U: i[31:12]→[31:12], rd→[11:7], opcode.
  - J: i[20]→31, i[10:1]→[30:21], i[11]→20, i[19:12]→[19:12], rd, opcode.
  - Fields a format does not use are ignored.
- Illegal type: the stored word is 0x00000000 and err=1.
- FIFO: 2 entries, occupancy counter 0..2, wrap-around read/write pointers.
  - `io_in_ready` = occupancy < 2. It is a function of registered state only, with no combinational path from `io_out_ready`.
  - When full, a simultaneous pop does not allow a push in the same cycle.
  - Push and pop in the same cycle at occupancy 1 leaves occupancy at 1.
- `io_out_valid` = occupancy != 0.
- While `io_out_valid` is 1 and `io_out_ready` is 0, `io_out_instruction` and `io_out_err` must stay stable.
- `io_err_count` increments on each input transfer whose err=1 and saturates at 0xFF.

## Timing
- Latency is 1 cycle. A request accepted at edge N is visible on the outputs after edge N, provided the FIFO was empty.
- Throughput is 1 word per cycle while `io_out_ready` stays high.
- Reset values:
  - Occupancy 0 and both pointers 0.
  - `io_out_valid`=0, `io_in_ready`=1.
  - `io_out_instruction`=0, `io_out_err`=0.
  - `io_err_count`=0.
- Reset asserted mid-operation discards all FIFO contents immediately; no words are emitted afterwards.
- FIFO storage is not reset. The outputs are gated to 0 when the FIFO is empty.

## Configuration
- Macro: `YSYX_25020077_IMMENC_RANGECHK_EN`.
- When defined, err is also set when the immediate does not fit its format. The word is still encoded with the truncated bits. The legality rules are:
  - I/S: i[31:11] must be all-equal (signed 12-bit).
  - B: i[31:12] must be all-equal and i[0]=0.
  - U: i[11:0]=0.
  - J: i[31:20] must be all-equal and i[0]=0.
- When undefined, no range check is done. err is set only for illegal types, and bits are truncated silently.

## Test plan
- I, S, B encodings:
  - I, imm=5, opcode 0x13, rd=1, rs1=0, funct3=0 → 0x00500093, err=0.
  - I, imm=0xFFFFFFFF → 0xFFF00093.
  - S, imm=8, opcode 0x23, funct3=2, rs1=1, rs2=2 → 0x0020A423.
  - B, imm=0xFFFFFFFC, opcode 0x63, rs1=rs2=0, funct3=0 → 0xFE000EE3.
- U and J encodings:
  - U, imm=0x12345000, rd=5, opcode 0x37 → 0x123452B7.
  - J, imm=0x800, rd=1, opcode 0x6F → 0x001000EF.
- Errors:
  - Type 6 → word 0x00000000, err=1, `io_err_count` 0→1.
  - I, imm=0x800 → with the macro, err=1 and word 0x80000093 (rd=1, opcode 0x13); without it, err=0.
- Backpressure:
  - Hold `io_out_ready`=0 and drive 3 back-to-back requests → `io_in_ready` drops after 2 accepts.
  - Release `io_out_ready` → both words emerge in order and the third request is accepted the cycle after the first pop.
- Saturation: 300 illegal-type requests → `io_err_count` stops at 0xFF.
- Reset mid-operation: assert `reset` with 2 entries queued → `io_out_valid`=0 and `io_in_ready`=1 immediately, and `io_err_count`=0.
